// File: rtl/delaychain_pkg.sv
// Shared types and constants for the delay-line measurement engine.
`timescale 1ns/1ps

package delaychain_pkg;

    // Capture taps per delay line and the matching count width.
    localparam int TAPS       = 16;
    localparam int CNT_W      = $clog2(TAPS + 1);
    // Number of clocks spent in ARM before each launch.
    localparam int ARM_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        WAIT,
        CAP1,
        CAP2,
        EVAL
    } state_t;

    // Returns {count, bubble}.
    // count is the number of contiguous ones starting at bit0.
    // bubble is set when any 1 appears above the first 0.
    function automatic logic [CNT_W:0] therm_to_count(input logic [TAPS-1:0] t);
        logic [CNT_W-1:0] cnt;
        logic             seen0;
        logic             bub;
        cnt   = '0;
        seen0 = 1'b0;
        bub   = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (!t[i])
                seen0 = 1'b1;
            else if (seen0)
                bub = 1'b1;
            else
                cnt = cnt + 1'b1;
        end
        return {cnt, bub};
    endfunction

endpackage

// File: rtl/delay_segment.sv
// One delay segment: a chain of STAGES buffers that is optionally bypassed.
// The buffers carry no delay in RTL simulation. They exist so that
// implementation keeps a real chain in place. The keep/dont_touch attributes
// stop the chain from being collapsed.
`timescale 1ns/1ps

module delay_segment #(
    parameter int STAGES = 4
) (
    input  logic din,
    input  logic bypass,
    output logic dout
);

    (* keep = "true", dont_touch = "true" *) logic [STAGES:0] stage;

    assign stage[0] = din;

    for (genvar g = 0; g < STAGES; g++) begin : g_buf
        assign stage[g+1] = stage[g];
    end

    // In bypass, the segment hands its input straight to the next segment.
    assign dout = bypass ? din : stage[STAGES];

endmodule

// File: rtl/delaychain_meter.sv
// Multi-channel delay-line meter.
// The FSM launches a rising edge into one channel and waits a programmed
// number of clocks. It then captures the tap thermometer code through two
// flop stages and reports how deep the edge travelled.
// Optional feature macro: DELAYCHAIN_AVG_EN. When it is defined, each start
// runs 2**AVG_LOG2 launches and tap_sum accumulates their counts.
// chan_sel is one bit wider than a plain channel index. The extra bit lets an
// out-of-range selection be expressed, so the meter can flag it.
`timescale 1ns/1ps

module delaychain_meter
    import delaychain_pkg::*;
#(
    parameter int   CHANNELS       = 8,
    parameter int   STAGES_PER_TAP = 4,
    parameter int   WAIT_W         = 8,
    parameter int   AVG_LOG2       = 2,
    localparam int  CHAN_W         = $clog2(CHANNELS) + 1,
    localparam int  SUM_W          = CNT_W + AVG_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAN_W-1:0] chan_sel,
    input  logic [WAIT_W-1:0] wait_cycles,
    input  logic              bypass,
    output logic              busy,
    output logic              done,
    output logic [TAPS-1:0]   therm,
    output logic [CNT_W-1:0]  tap_count,
    output logic [SUM_W-1:0]  tap_sum,
    output logic              err
);

    localparam int               ARM_W    = $clog2(ARM_CYCLES);
    localparam logic [CHAN_W-1:0] CHAN_LIM = CHAN_W'(CHANNELS);

    state_t                state, next;
    logic [ARM_W-1:0]      arm_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_q;
    logic [CHAN_W-1:0]     chan_q;
    logic                  bad_q;
    logic [CHANNELS-1:0]   launch_lines;
    logic [CHANNELS-1:0]   launch_d;
    logic [TAPS-1:0]       tap_arr [CHANNELS];
    logic [TAPS-1:0]       tap_sel;
    logic [TAPS-1:0]       tap_q;
    logic [TAPS-1:0]       sync_q;
    logic [CNT_W:0]        eval_res;
    logic                  last_rep;

    // Delay lines: each tap output feeds the next segment and one capture bit.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        for (genvar t = 0; t < TAPS; t++) begin : g_tap
            logic seg_in;
            logic seg_out;
            if (t == 0) begin : g_first
                assign seg_in = launch_lines[c];
            end else begin : g_next
                assign seg_in = g_tap[t-1].seg_out;
            end
            delay_segment #(.STAGES(STAGES_PER_TAP)) u_seg (
                .din    (seg_in),
                .bypass (bypass),
                .dout   (seg_out)
            );
            assign tap_arr[c][t] = seg_out;
        end
    end

    assign tap_sel  = tap_arr[chan_q[CHAN_W-2:0]];
    assign eval_res = therm_to_count(sync_q);

`ifdef DELAYCHAIN_AVG_EN
    logic [AVG_LOG2-1:0] rep_cnt;
    assign last_rep = &rep_cnt;
`else
    assign last_rep = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    // Next-state logic and per-channel launch levels.
    // launch_d is computed from next, so the registered launch line rises
    // on the same edge that enters LAUNCH.
    always_comb begin
        next     = state;
        launch_d = '0;
        case (state)
            IDLE:    if (start) next = (chan_sel >= CHAN_LIM) ? EVAL : ARM;
            ARM:     if (arm_cnt == '0) next = LAUNCH;
            LAUNCH:  next = (wait_q == '0) ? CAP1 : WAIT;
            WAIT:    if (wait_cnt == WAIT_W'(1)) next = CAP1;
            CAP1:    next = CAP2;
            CAP2:    next = EVAL;
            EVAL:    next = (!bad_q && !last_rep) ? ARM : IDLE;
            default: next = IDLE;
        endcase
        if (next == LAUNCH || next == WAIT || next == CAP1)
            launch_d[chan_q[CHAN_W-2:0]] = 1'b1;
    end

    // Timers, capture pipeline, result registers and handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            therm        <= '0;
            tap_count    <= '0;
            tap_sum      <= '0;
            err          <= 1'b0;
            arm_cnt      <= '0;
            wait_cnt     <= '0;
            wait_q       <= '0;
            chan_q       <= '0;
            bad_q        <= 1'b0;
            tap_q        <= '0;
            sync_q       <= '0;
            launch_lines <= '0;
`ifdef DELAYCHAIN_AVG_EN
            rep_cnt      <= '0;
`endif
        end else begin
            done         <= 1'b0;
            launch_lines <= launch_d;

            if (state == IDLE && start) begin
                busy      <= 1'b1;
                chan_q    <= chan_sel;
                wait_q    <= wait_cycles;
                bad_q     <= (chan_sel >= CHAN_LIM);
                therm     <= '0;
                tap_count <= '0;
                tap_sum   <= '0;
                err       <= 1'b0;
`ifdef DELAYCHAIN_AVG_EN
                rep_cnt   <= '0;
`endif
            end

            if (state != ARM && next == ARM)
                arm_cnt <= ARM_W'(ARM_CYCLES - 1);
            else if (state == ARM)
                arm_cnt <= arm_cnt - 1'b1;

            if (state == LAUNCH)
                wait_cnt <= wait_q;
            else if (state == WAIT)
                wait_cnt <= wait_cnt - 1'b1;

            if (state == CAP1)
                tap_q <= tap_sel;
            if (state == CAP2)
                sync_q <= tap_q;

            if (state == EVAL) begin
                if (bad_q) begin
                    err <= 1'b1;
                end else begin
                    therm     <= sync_q;
                    tap_count <= eval_res[CNT_W:1];
                    err       <= err | eval_res[0];
`ifdef DELAYCHAIN_AVG_EN
                    tap_sum   <= tap_sum + SUM_W'(eval_res[CNT_W:1]);
                    rep_cnt   <= rep_cnt + 1'b1;
`else
                    tap_sum   <= SUM_W'(eval_res[CNT_W:1]);
`endif
                end
                if (next == IDLE) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule
